// File: rtl/silife_sequencer.sv
// SiLife sequencer: Wishbone-mapped generation-step generator (free-run, run-N, single step)
// with generation counter, MAX7219 configuration and a maskable interrupt.
module silife_sequencer #(
  parameter int unsigned PERIOD_WIDTH = 24,
  parameter int unsigned PERIOD_RESET = 999,
  parameter int unsigned STEPS_WIDTH  = 16,
  parameter int unsigned GEN_WIDTH    = 32,
  parameter logic [11:0] REG_PAGE     = 12'h000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_wb_cyc,
  input  logic        i_wb_stb,
  input  logic        i_wb_we,
  input  logic [31:0] i_wb_addr,
  input  logic [31:0] i_wb_data,
  output logic        o_wb_ack,
  output logic [31:0] o_wb_data,
  output logic        o_step,
  output logic        o_busy,
  output logic        o_max7219_enable,
  output logic [3:0]  o_max7219_brightness,
  output logic        o_irq
);
  typedef enum logic [1:0] {StIdle, StRun, StStepN} state_e;

  localparam logic [7:0] OffCtrl   = 8'h00;
  localparam logic [7:0] OffMax    = 8'h04;
  localparam logic [7:0] OffPeriod = 8'h08;
  localparam logic [7:0] OffSteps  = 8'h0C;
  localparam logic [7:0] OffGen    = 8'h10;
  localparam logic [7:0] OffIrqSt  = 8'h14;
  localparam logic [7:0] OffIrqEn  = 8'h18;

  state_e                  r_state, w_state_d;
  logic [PERIOD_WIDTH-1:0] r_cnt, w_cnt_d;
  logic [PERIOD_WIDTH-1:0] r_period, w_period_d;
  logic [STEPS_WIDTH-1:0]  r_steps, w_steps_d;
  logic [GEN_WIDTH-1:0]    r_gen, w_gen_d;
  logic [1:0]              r_irq_status, w_irq_status_d;
  logic [1:0]              r_irq_en, w_irq_en_d;
  logic                    r_max_en, w_max_en_d;
  logic [3:0]              r_max_bright, w_max_bright_d;
  logic                    r_single, w_single_d;
  logic                    r_ack;
  logic [31:0]             r_rdata, w_rdata;

  logic                    w_sel, w_wr;
  logic [7:0]              w_off;
  logic                    w_wr_ctrl, w_wr_max, w_wr_period, w_wr_steps;
  logic                    w_wr_gen, w_wr_irq_st, w_wr_irq_en;
  logic [STEPS_WIDTH-1:0]  w_steps_wdata;
  logic                    w_pre_step, w_step;
  logic                    w_done_set, w_wrap_set;
  logic [1:0]              w_irq_clr;
  logic                    w_unused;

  assign w_sel = i_wb_cyc & i_wb_stb & (i_wb_addr[23:12] == REG_PAGE) & ~r_ack;
  assign w_wr  = w_sel & i_wb_we;
  assign w_off = i_wb_addr[7:0];

  assign w_wr_ctrl     = w_wr && (w_off == OffCtrl);
  assign w_wr_max      = w_wr && (w_off == OffMax);
  assign w_wr_period   = w_wr && (w_off == OffPeriod);
  assign w_wr_steps    = w_wr && (w_off == OffSteps);
  assign w_wr_gen      = w_wr && (w_off == OffGen);
  assign w_wr_irq_st   = w_wr && (w_off == OffIrqSt);
  assign w_wr_irq_en   = w_wr && (w_off == OffIrqEn);
  assign w_steps_wdata = i_wb_data[STEPS_WIDTH-1:0];

  // >= rather than == so a PERIOD shrunk below the running count fires at once.
  assign w_pre_step = (r_state != StIdle) && (r_cnt >= r_period);
  assign w_step     = w_pre_step | r_single;

  always_comb begin
    w_state_d      = r_state;
    w_cnt_d        = '0;
    w_steps_d      = r_steps;
    w_gen_d        = r_gen;
    w_period_d     = r_period;
    w_max_en_d     = r_max_en;
    w_max_bright_d = r_max_bright;
    w_irq_en_d     = r_irq_en;
    w_single_d     = 1'b0;
    w_done_set     = 1'b0;
    w_wrap_set     = 1'b0;
    w_irq_clr      = 2'b00;

    if (w_step) begin
      w_gen_d    = r_gen + GEN_WIDTH'(1);
      w_wrap_set = &r_gen;
    end

    case (r_state)
      StIdle: begin
        if (w_wr_ctrl && i_wb_data[0]) begin
          w_state_d = StRun;
        end else if (w_wr_steps && (w_steps_wdata != '0)) begin
          w_state_d = StStepN;
          w_steps_d = w_steps_wdata;
        end
        if (w_wr_ctrl && i_wb_data[1]) w_single_d = 1'b1;
      end
      StRun: begin
        if (w_wr_ctrl && !i_wb_data[0]) w_state_d = StIdle;
      end
      StStepN: begin
        if (w_pre_step) begin
          w_steps_d = r_steps - STEPS_WIDTH'(1);
          if (r_steps == STEPS_WIDTH'(1)) begin
            w_state_d  = StIdle;
            w_done_set = 1'b1;
          end
        end
      end
      default: w_state_d = StIdle;
    endcase

    // A zero STEPS write aborts from any state and cancels a completion on the same cycle.
    if (w_wr_steps && (w_steps_wdata == '0)) begin
      w_state_d  = StIdle;
      w_steps_d  = '0;
      w_done_set = 1'b0;
    end

    if (w_wr_gen)    w_gen_d    = '0;
    if (w_wr_period) w_period_d = i_wb_data[PERIOD_WIDTH-1:0];
    if (w_wr_max) begin
      w_max_en_d     = i_wb_data[0];
      w_max_bright_d = i_wb_data[4:1];
    end
    if (w_wr_irq_en) w_irq_en_d = i_wb_data[1:0];
    if (w_wr_irq_st) w_irq_clr  = i_wb_data[1:0];
    w_irq_status_d = (r_irq_status & ~w_irq_clr) | {w_wrap_set, w_done_set};

    if ((w_state_d == r_state) && (r_state != StIdle) && !w_pre_step) begin
      w_cnt_d = r_cnt + PERIOD_WIDTH'(1);
    end
  end

  always_comb begin
    w_rdata = '0;
    case (w_off)
      OffCtrl:   w_rdata = {29'd0, (r_state != StIdle), 1'b0, (r_state == StRun)};
      OffMax:    w_rdata = {27'd0, r_max_bright, r_max_en};
      OffPeriod: w_rdata = 32'(r_period);
      OffSteps:  w_rdata = 32'(r_steps);
      OffGen:    w_rdata = 32'(r_gen);
      OffIrqSt:  w_rdata = {30'd0, r_irq_status};
      OffIrqEn:  w_rdata = {30'd0, r_irq_en};
      default:   w_rdata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= StIdle;
      r_cnt        <= '0;
      r_period     <= PERIOD_WIDTH'(PERIOD_RESET);
      r_steps      <= '0;
      r_gen        <= '0;
      r_irq_status <= '0;
      r_irq_en     <= '0;
      r_max_en     <= 1'b0;
      r_max_bright <= 4'hF;
      r_single     <= 1'b0;
      r_ack        <= 1'b0;
      r_rdata      <= '0;
    end else begin
      r_state      <= w_state_d;
      r_cnt        <= w_cnt_d;
      r_period     <= w_period_d;
      r_steps      <= w_steps_d;
      r_gen        <= w_gen_d;
      r_irq_status <= w_irq_status_d;
      r_irq_en     <= w_irq_en_d;
      r_max_en     <= w_max_en_d;
      r_max_bright <= w_max_bright_d;
      r_single     <= w_single_d;
      r_ack        <= w_sel;
      if (w_sel) r_rdata <= w_rdata;
    end
  end

  assign o_wb_ack             = r_ack;
  assign o_wb_data            = r_rdata;
  assign o_step               = w_step;
  assign o_busy               = (r_state != StIdle);
  assign o_max7219_enable     = r_max_en;
  assign o_max7219_brightness = r_max_bright;
  assign o_irq                = |(r_irq_status & r_irq_en);

  assign w_unused = ^{i_wb_addr[31:24], i_wb_addr[11:8], i_wb_data};

endmodule

// File: tb/tb_silife_sequencer.sv
// Self-checking bench for silife_sequencer: cycle-level behavioural model plus directed
// scenarios with literal expectations.
module tb_silife_sequencer;
  localparam int GW = 4;

  logic        clk   = 1'b0;
  logic        reset = 1'b0;
  logic        cyc   = 1'b0;
  logic        stb   = 1'b0;
  logic        we    = 1'b0;
  logic [31:0] addr  = '0;
  logic [31:0] wdata = '0;
  logic        o_wb_ack;
  logic [31:0] o_wb_data;
  logic        o_step, o_busy, o_max7219_enable, o_irq;
  logic [3:0]  o_max7219_brightness;

  silife_sequencer #(.GEN_WIDTH(GW)) dut (
    .clk                  (clk),
    .reset                (reset),
    .i_wb_cyc             (cyc),
    .i_wb_stb             (stb),
    .i_wb_we              (we),
    .i_wb_addr            (addr),
    .i_wb_data            (wdata),
    .o_wb_ack             (o_wb_ack),
    .o_wb_data            (o_wb_data),
    .o_step               (o_step),
    .o_busy               (o_busy),
    .o_max7219_enable     (o_max7219_enable),
    .o_max7219_brightness (o_max7219_brightness),
    .o_irq                (o_irq)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int tcyc     = 0;
  int stepq[$];

  initial forever begin
    @(posedge clk);
    tcyc++;
  end

  initial forever begin
    @(negedge clk);
    if (reset && o_step) stepq.push_back(tcyc);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, required %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef enum int {MIdle, MRun, MStepN} mmode_e;
  mmode_e      m_mode    = MIdle;
  int          m_age     = 0;   // cycles since the current mode was entered
  int          m_period  = 999;
  int          m_steps   = 0;
  int          m_gen     = 0;
  bit          m_done    = 0;
  bit          m_wrap    = 0;
  logic [1:0]  m_irq_en  = '0;
  bit          m_max_en  = 0;
  logic [3:0]  m_bright  = 4'hF;
  bit          m_single  = 0;
  bit          m_ack     = 0;
  bit          m_ack_rd  = 0;
  logic [31:0] m_rdata   = '0;

  function automatic bit model_pre_step();
    return (m_mode != MIdle) && ((m_age % (m_period + 1)) == m_period);
  endfunction

  function automatic bit model_step();
    return model_pre_step() || m_single;
  endfunction

  task automatic model_reset();
    m_mode = MIdle; m_age = 0; m_period = 999; m_steps = 0; m_gen = 0;
    m_done = 0; m_wrap = 0; m_irq_en = '0; m_max_en = 0; m_bright = 4'hF;
    m_single = 0; m_ack = 0; m_ack_rd = 0; m_rdata = '0;
  endtask

  task automatic model_update();
    bit          pre, step, sel, wr, done_set, wrap_set, n_single;
    logic [7:0]  off;
    logic [1:0]  clr;
    logic [31:0] rd;
    mmode_e      n_mode;
    int          n_steps, n_gen, n_period;
    pre      = model_pre_step();
    step     = model_step();
    sel      = cyc && stb && (addr[23:12] == 12'h000) && !m_ack;
    wr       = sel && we;
    off      = addr[7:0];
    n_mode   = m_mode;
    n_steps  = m_steps;
    n_gen    = m_gen;
    n_period = m_period;
    n_single = 0;
    done_set = 0;
    wrap_set = 0;
    clr      = 2'b00;
    if (step) begin
      n_gen    = (m_gen + 1) % (1 << GW);
      wrap_set = (m_gen == (1 << GW) - 1);
    end
    if (pre && m_mode == MStepN) begin
      n_steps = m_steps - 1;
      if (n_steps == 0) begin
        n_mode   = MIdle;
        done_set = 1;
      end
    end
    case (off)
      8'h00:   rd = {29'd0, (m_mode != MIdle), 1'b0, (m_mode == MRun)};
      8'h04:   rd = {27'd0, m_bright, m_max_en};
      8'h08:   rd = m_period;
      8'h0C:   rd = m_steps;
      8'h10:   rd = m_gen;
      8'h14:   rd = {30'd0, m_wrap, m_done};
      8'h18:   rd = {30'd0, m_irq_en};
      default: rd = '0;
    endcase
    if (wr) begin
      case (off)
        8'h00: begin
          if (m_mode == MIdle && wdata[0]) n_mode = MRun;
          if (m_mode == MRun && !wdata[0]) n_mode = MIdle;
          n_single = (m_mode == MIdle) && wdata[1];
        end
        8'h04: begin
          m_max_en = wdata[0];
          m_bright = wdata[4:1];
        end
        8'h08: n_period = int'(wdata[23:0]);
        8'h0C: begin
          if (wdata[15:0] == 16'd0) begin
            n_mode   = MIdle;
            n_steps  = 0;
            done_set = 0;
          end else if (m_mode == MIdle) begin
            n_mode  = MStepN;
            n_steps = int'(wdata[15:0]);
          end
        end
        8'h10: n_gen = 0;
        8'h14: clr = wdata[1:0];
        8'h18: m_irq_en = wdata[1:0];
        default: ;
      endcase
    end
    m_done   = (m_done && !clr[0]) || done_set;
    m_wrap   = (m_wrap && !clr[1]) || wrap_set;
    m_age    = (n_mode != m_mode) ? 0 : m_age + 1;
    m_mode   = n_mode;
    m_steps  = n_steps;
    m_gen    = n_gen;
    m_period = n_period;
    m_single = n_single;
    m_ack    = sel;
    m_ack_rd = sel && !we;
    if (sel) m_rdata = rd;
  endtask

  initial forever begin
    @(posedge clk or negedge reset);
    if (!reset) model_reset();
    else        model_update();
  end

  // Compare process: outputs are register-driven, so mid-cycle sampling is stable.
  initial forever begin
    @(negedge clk);
    if (reset) begin
      check1("m_step", o_step, model_step());
      check1("m_busy", o_busy, m_mode != MIdle);
      check1("m_irq", o_irq, |({m_wrap, m_done} & m_irq_en));
      check1("m_ack", o_wb_ack, m_ack);
      check1("m_max_en", o_max7219_enable, m_max_en);
      check("m_bright", {28'd0, o_max7219_brightness}, {28'd0, m_bright});
      if (m_ack && m_ack_rd) check("m_rdata", o_wb_data, m_rdata);
    end
  end

  // ---------------- bus tasks ----------------
  task automatic wb_xfer(input bit w, input logic [31:0] a, input logic [31:0] d,
                         output logic [31:0] r);
    bit got;
    got = 0;
    r   = '0;
    @(negedge clk);
    cyc = 1; stb = 1; we = w; addr = a; wdata = d;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      if (o_wb_ack) begin
        got = 1;
        r   = o_wb_data;
      end
    end
    cyc = 0; stb = 0; we = 0;
    n_checks++;
    if (!got) begin
      n_fail++;
      $display("FAIL wb_ack_timeout: addr 0x%0h got no ack, required ack within 8 cycles", a);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] r;
    wb_xfer(1'b1, a, d, r);
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] r);
    wb_xfer(1'b0, a, 32'd0, r);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish before 200us");
    $fatal(1);
  end

  // ---------------- directed scenarios ----------------
  initial begin
    logic [31:0] r;
    int acks;
    int t;
    r = '0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check1("rst_step", o_step, 1'b0);
    check1("rst_busy", o_busy, 1'b0);
    check1("rst_irq", o_irq, 1'b0);
    check1("rst_ack", o_wb_ack, 1'b0);
    check("rst_wb_data", o_wb_data, 32'd0);
    check1("rst_max_en", o_max7219_enable, 1'b0);
    check("rst_bright", {28'd0, o_max7219_brightness}, 32'hF);

    // strobe held across the ack: exactly one ack
    @(negedge clk);
    cyc = 1; stb = 1; we = 0; addr = 32'h04;
    acks = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (o_wb_ack) begin
        acks++;
        r = o_wb_data;
      end
      if (i == 1) begin
        cyc = 0; stb = 0;
      end
    end
    check("held_ack_count", acks, 1);
    check("rd_max7219", r, 32'h1E);
    rd(32'h08, r); check("rd_period_rst", r, 32'd999);
    rd(32'h00, r); check("rd_ctrl_rst", r, 32'd0);
    rd(32'h40, r); check("rd_unmapped", r, 32'd0);

    // free-run, PERIOD=3
    wr(32'h08, 32'd3);
    stepq.delete();
    wr(32'h00, 32'd1);
    t = tcyc;
    repeat (12) @(negedge clk);
    check("run_nsteps", stepq.size(), 3);
    if (stepq.size() == 3) begin
      check("run_step1", stepq[0] - t, 3);
      check("run_step2", stepq[1] - t, 7);
      check("run_step3", stepq[2] - t, 11);
    end
    wr(32'h00, 32'd0);
    check1("run_stop_busy", o_busy, 1'b0);
    rd(32'h10, r); check("run_gen", r, 32'd3);

    // run-N, PERIOD=0
    wr(32'h08, 32'd0);
    stepq.delete();
    wr(32'h0C, 32'd5);
    t = tcyc;
    repeat (8) @(negedge clk);
    check("stepn_nsteps", stepq.size(), 5);
    for (int k = 0; k < stepq.size(); k++) check("stepn_cadence", stepq[k] - t, k);
    check1("stepn_busy", o_busy, 1'b0);
    rd(32'h14, r); check("stepn_status", r, 32'd1);
    rd(32'h0C, r); check("stepn_steps", r, 32'd0);
    wr(32'h18, 32'd1);
    check1("irq_set", o_irq, 1'b1);
    wr(32'h14, 32'd1);
    check1("irq_clr", o_irq, 1'b0);

    // single step in IDLE, then ignored in RUN
    wr(32'h10, 32'd0);
    stepq.delete();
    wr(32'h00, 32'd2);
    t = tcyc;
    repeat (3) @(negedge clk);
    check("single_nsteps", stepq.size(), 1);
    if (stepq.size() == 1) check("single_when", stepq[0] - t, 0);
    rd(32'h10, r); check("single_gen", r, 32'd1);
    wr(32'h08, 32'd100);
    wr(32'h00, 32'd1);
    rd(32'h00, r); check("ctrl_running", r, 32'd5);
    stepq.delete();
    wr(32'h00, 32'd3);
    repeat (4) @(negedge clk);
    check("single_in_run", stepq.size(), 0);
    wr(32'h00, 32'd0);
    rd(32'h10, r); check("single_in_run_gen", r, 32'd1);

    // 17 steps with a 4-bit generation counter: wraps once
    wr(32'h10, 32'd0);
    wr(32'h08, 32'd0);
    stepq.delete();
    wr(32'h0C, 32'd17);
    repeat (20) @(negedge clk);
    check("wrap_nsteps", stepq.size(), 17);
    rd(32'h10, r); check("wrap_gen", r, 32'd1);
    rd(32'h14, r); check("wrap_status", r, 32'd3);
    wr(32'h14, 32'd3);
    rd(32'h14, r); check("status_w1c", r, 32'd0);

    // abort on a step cycle: gen counts, DONE stays clear
    wr(32'h0C, 32'd10);
    repeat (2) @(negedge clk);
    wr(32'h0C, 32'd0);
    check1("abort_busy", o_busy, 1'b0);
    rd(32'h14, r); check("abort_status", r, 32'd0);
    rd(32'h10, r); check("abort_gen", r, 32'd5);
    rd(32'h0C, r); check("abort_steps", r, 32'd0);

    // asynchronous reset in the middle of run-N
    wr(32'h0C, 32'd100);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2;
    check1("pre_reset_step", o_step, 1'b1);
    reset = 1'b0;
    #1;
    check1("async_rst_step", o_step, 1'b0);
    check1("async_rst_busy", o_busy, 1'b0);
    check1("async_rst_irq", o_irq, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    rd(32'h0C, r); check("post_rst_steps", r, 32'd0);
    rd(32'h10, r); check("post_rst_gen", r, 32'd0);
    rd(32'h14, r); check("post_rst_status", r, 32'd0);
    rd(32'h08, r); check("post_rst_period", r, 32'd999);
    rd(32'h18, r); check("post_rst_irq_en", r, 32'd0);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
